// File: rtl/vls_sequencer.sv
//-----------------------------------------------------------------------------
// vls_sequencer
//
// Vector load/store sequencer. A single Start strobe (sampled only while idle)
// captures a vector operation and then issues one 16-bit memory access per
// element over a single shared memory port, honouring a per-cycle grant.
//   VST : writes StoreData element i to BaseAddr + i*stride.
//   VLD : reads BaseAddr + i*stride; the data returned one cycle after each
//         read strobe is packed into LoadData element i.
// Addresses wrap modulo 2^16 silently.
//
// Configuration macro:
//   VLS_STRIDE_EN  defined   -> Stride port present, captured with Start.
//                  undefined -> no Stride port, stride fixed at 1.
//
// Ports:
//   Clk1        in   sole clock, rising edge
//   Reset       in   synchronous, active-high
//   Start       in   operation request (ignored while Busy)
//   IsStore     in   1 = VST, 0 = VLD
//   BaseAddr    in   [15:0] element-0 word address
//   Stride      in   [15:0] element address increment (VLS_STRIDE_EN only)
//   StoreData   in   [16*NUM_ELEM-1:0] store vector, element i = [16i+15:16i]
//   MemGnt      in   memory port granted this cycle
//   MemDataIn   in   [15:0] read data, valid the cycle after MemRD
//   MemAddr     out  [15:0] word address of the current access
//   MemRD       out  read strobe
//   MemWR       out  write strobe
//   MemDataOut  out  [15:0] write data
//   LoadData    out  [16*NUM_ELEM-1:0] assembled load vector
//   Busy        out  high in every state except IDLE
//   Done        out  one-cycle completion pulse
//-----------------------------------------------------------------------------
module vls_sequencer #(
  parameter int NUM_ELEM = 16
) (
  input  logic                   Clk1,
  input  logic                   Reset,
  input  logic                   Start,
  input  logic                   IsStore,
  input  logic [15:0]            BaseAddr,
`ifdef VLS_STRIDE_EN
  input  logic [15:0]            Stride,
`endif
  input  logic [16*NUM_ELEM-1:0] StoreData,
  input  logic                   MemGnt,
  input  logic [15:0]            MemDataIn,
  output logic [15:0]            MemAddr,
  output logic                   MemRD,
  output logic                   MemWR,
  output logic [15:0]            MemDataOut,
  output logic [16*NUM_ELEM-1:0] LoadData,
  output logic                   Busy,
  output logic                   Done
);

  localparam int          IDX_W    = 4;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ELEM - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                  state_r;
  logic                    is_store_r;
  logic [15:0]             addr_r;       // BaseAddr + idx*stride, kept as a running sum
  logic [16*NUM_ELEM-1:0]  store_data_r;
  logic [IDX_W-1:0]        idx_r;
  logic                    pend_r;       // a read was issued last cycle
  logic [IDX_W-1:0]        pend_idx_r;   // element that read belongs to
  logic [16*NUM_ELEM-1:0]  load_data_r;
  logic                    busy_r;
  logic                    done_r;
  logic [15:0]             stride_s;
  logic                    issue_s;

`ifdef VLS_STRIDE_EN
  logic [15:0]             stride_r;

  // Stride comes from the value captured with Start.
  always_comb begin
    stride_s = stride_r;
  end
`else
  // Without the stride option, elements occupy consecutive words.
  always_comb begin
    stride_s = 16'h0001;
  end
`endif

  // Memory-port drive: strobes follow the grant combinationally while issuing.
  always_comb begin
    issue_s    = 1'b0;
    MemRD      = 1'b0;
    MemWR      = 1'b0;
    MemAddr    = 16'h0000;
    MemDataOut = 16'h0000;
    if (state_r == ST_ISSUE) begin
      issue_s = MemGnt;
      MemAddr = addr_r;
      if (MemGnt) begin
        MemRD = ~is_store_r;
        MemWR = is_store_r;
        if (is_store_r) begin
          MemDataOut = store_data_r[{idx_r, 4'b0000} +: 16];
        end else begin
          MemDataOut = 16'h0000;
        end
      end else begin
        MemRD = 1'b0;
        MemWR = 1'b0;
      end
    end else begin
      issue_s = 1'b0;
    end
  end

  assign LoadData = load_data_r;
  assign Busy     = busy_r;
  assign Done     = done_r;

  // Sequencer FSM, operand capture and load-data assembly.
  always_ff @(posedge Clk1) begin
    if (Reset) begin
      state_r      <= ST_IDLE;
      is_store_r   <= 1'b0;
      addr_r       <= 16'h0000;
      store_data_r <= '0;
      idx_r        <= '0;
      pend_r       <= 1'b0;
      pend_idx_r   <= '0;
      load_data_r  <= '0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
`ifdef VLS_STRIDE_EN
      stride_r     <= 16'h0000;
`endif
    end else begin
      // Read data returns one cycle after its strobe, whatever the state or
      // grant is now; a fresh read this cycle re-arms the flag below.
      pend_r <= 1'b0;
      if (pend_r) begin
        load_data_r[{pend_idx_r, 4'b0000} +: 16] <= MemDataIn;
      end

      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (Start) begin
            is_store_r   <= IsStore;
            addr_r       <= BaseAddr;
            store_data_r <= StoreData;
`ifdef VLS_STRIDE_EN
            stride_r     <= Stride;
`endif
            idx_r        <= '0;
            busy_r       <= 1'b1;
            state_r      <= ST_ISSUE;
          end else begin
            busy_r       <= 1'b0;
          end
        end

        ST_ISSUE: begin
          if (issue_s) begin
            if (!is_store_r) begin
              pend_r     <= 1'b1;
              pend_idx_r <= idx_r;
            end
            addr_r <= addr_r + stride_s;
            idx_r  <= idx_r + 4'd1;
            if (idx_r == LAST_IDX) begin
              // Stores are complete on the last grant; loads still wait
              // for the final element's data.
              if (is_store_r) begin
                state_r <= ST_DONE;
                done_r  <= 1'b1;
              end else begin
                state_r <= ST_DRAIN;
              end
            end
          end
        end

        ST_DRAIN: begin
          state_r <= ST_DONE;
          done_r  <= 1'b1;
        end

        ST_DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end

        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vls_sequencer.sv
module tb_vls_sequencer;

  logic         Clk1;
  logic         Reset;
  logic         Start;
  logic         IsStore;
  logic [15:0]  BaseAddr;
`ifdef VLS_STRIDE_EN
  logic [15:0]  Stride;
`endif
  logic [255:0] StoreData;
  logic         MemGnt;
  logic [15:0]  MemDataIn;
  logic [15:0]  MemAddr;
  logic         MemRD;
  logic         MemWR;
  logic [15:0]  MemDataOut;
  logic [255:0] LoadData;
  logic         Busy;
  logic         Done;

  int n_vec = 0;
  int n_err = 0;

  logic [255:0] model_load;
  logic [15:0]  exp_addr_q[$];
  logic [15:0]  exp_wdata_q[$];

  vls_sequencer #(.NUM_ELEM(16)) dut (
    .Clk1       (Clk1),
    .Reset      (Reset),
    .Start      (Start),
    .IsStore    (IsStore),
    .BaseAddr   (BaseAddr),
`ifdef VLS_STRIDE_EN
    .Stride     (Stride),
`endif
    .StoreData  (StoreData),
    .MemGnt     (MemGnt),
    .MemDataIn  (MemDataIn),
    .MemAddr    (MemAddr),
    .MemRD      (MemRD),
    .MemWR      (MemWR),
    .MemDataOut (MemDataOut),
    .LoadData   (LoadData),
    .Busy       (Busy),
    .Done       (Done)
  );

  initial Clk1 = 1'b0;
  always #5 Clk1 = ~Clk1;

  // Memory contents model: word at address a holds a + 0x0F00,
  // so memory[0x0100+i] = 0x1000+i.
  function automatic logic [15:0] mem_val(input logic [15:0] a);
    return a + 16'h0F00;
  endfunction

  function automatic logic [255:0] mk_sdata(input logic [15:0] seed);
    logic [255:0] v;
    v = '0;
    for (int i = 0; i < 16; i++) v[16*i +: 16] = seed + 16'(i);
    return v;
  endfunction

  // Runs one vector operation cycle by cycle. Cycle k = k-th cycle after
  // the edge that accepted Start.
  task automatic drive_op(input logic is_store, input logic [15:0] base,
                          input logic [15:0] stride, input logic [255:0] sdata,
                          input int gnt_mode, input int exp_done_k,
                          input int loop_len, input int rst_after_wr,
                          input int busy_start_k, input logic [15:0] busy_base);
    logic [255:0] new_load;
    logic [15:0]  a;
    logic [15:0]  ea;
    logic [15:0]  ed;
    logic         rd_prev;
    logic [15:0]  rd_prev_addr;
    int           wr_cnt;
    int           done_cnt;
    bit           aborted;
    bit           rst_check;

    exp_addr_q.delete();
    exp_wdata_q.delete();
    new_load = '0;
    a = base;
    for (int i = 0; i < 16; i++) begin
      exp_addr_q.push_back(a);
      exp_wdata_q.push_back(sdata[16*i +: 16]);
      new_load[16*i +: 16] = mem_val(a);
      a = a + stride;
    end

    @(negedge Clk1);
    IsStore   = is_store;
    BaseAddr  = base;
`ifdef VLS_STRIDE_EN
    Stride    = stride;
`endif
    StoreData = sdata;
    MemGnt    = 1'b1;
    MemDataIn = 16'h0000;
    Start     = 1'b1;

    rd_prev = 1'b0; rd_prev_addr = 16'h0000;
    wr_cnt = 0; done_cnt = 0; aborted = 1'b0; rst_check = 1'b0;

    for (int k = 1; k <= loop_len; k++) begin
      @(negedge Clk1);
      if (k == busy_start_k) begin
        Start    = 1'b1;
        BaseAddr = busy_base;
      end else begin
        Start = 1'b0;
      end
      MemGnt    = (gnt_mode == 0) ? 1'b1 : ((k % 2) == 1);
      MemDataIn = rd_prev ? mem_val(rd_prev_addr) : 16'hDEAD;
      if (rst_check) Reset = 1'b0;
      #1;

      if (k == 1 && rst_after_wr == 0) begin
        n_vec++;
        if (Busy !== 1'b1) begin
          n_err++; $display("FAIL busy_k1 got %b exp 1", Busy);
        end
      end

      if (rst_check) begin
        rst_check = 1'b0;
        n_vec++;
        if (MemWR !== 1'b0 || Busy !== 1'b0) begin
          n_err++; $display("FAIL abort_state MemWR=%b Busy=%b exp 0 0", MemWR, Busy);
        end
      end

      if (MemRD === 1'b1 && MemWR === 1'b1) begin
        n_err++; $display("FAIL rd_wr_both k=%0d got 1/1 exp exclusive", k);
      end

      if (MemRD === 1'b1 || MemWR === 1'b1) begin
        n_vec++;
        if (exp_addr_q.size() == 0) begin
          n_err++; $display("FAIL extra_access k=%0d addr %h exp none", k, MemAddr);
        end else begin
          ea = exp_addr_q.pop_front();
          ed = exp_wdata_q.pop_front();
          if (MemAddr !== ea || MemWR !== is_store) begin
            n_err++;
            $display("FAIL access k=%0d addr %h wr %b exp addr %h wr %b", k, MemAddr, MemWR, ea, is_store);
          end else if (is_store && MemDataOut !== ed) begin
            n_err++; $display("FAIL wdata k=%0d got %h exp %h", k, MemDataOut, ed);
          end
        end
        if (MemWR === 1'b1) wr_cnt++;
      end
      rd_prev      = (MemRD === 1'b1);
      rd_prev_addr = MemAddr;

      if (Done === 1'b1) begin
        done_cnt++;
        n_vec++;
        if (k != exp_done_k) begin
          n_err++; $display("FAIL done_cycle got k=%0d exp k=%0d", k, exp_done_k);
        end
      end

      if (rst_after_wr != 0 && !aborted && wr_cnt == rst_after_wr) begin
        Reset     = 1'b1;
        aborted   = 1'b1;
        rst_check = 1'b1;
        exp_addr_q.delete();
        exp_wdata_q.delete();
        model_load = '0;
      end
    end

    n_vec++;
    if (done_cnt != ((exp_done_k > 0) ? 1 : 0)) begin
      n_err++; $display("FAIL done_count got %0d exp %0d", done_cnt, (exp_done_k > 0) ? 1 : 0);
    end
    n_vec++;
    if (exp_addr_q.size() != 0) begin
      n_err++; $display("FAIL missing_access got %0d left exp 0", exp_addr_q.size());
    end
    if (!aborted && !is_store) model_load = new_load;
    n_vec++;
    if (LoadData !== model_load) begin
      n_err++; $display("FAIL loaddata got %h exp %h", LoadData, model_load);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1; Start = 1'b0; IsStore = 1'b0; BaseAddr = 16'h0000;
`ifdef VLS_STRIDE_EN
    Stride = 16'h0001;
`endif
    StoreData = '0; MemGnt = 1'b0; MemDataIn = 16'h0000;
    model_load = '0;
    repeat (2) @(negedge Clk1);
    #1;
    n_vec++;
    if ({Busy, Done, MemRD, MemWR} !== 4'b0000 || MemAddr !== 16'h0000 ||
        MemDataOut !== 16'h0000 || LoadData !== 256'h0) begin
      n_err++;
      $display("FAIL reset_state got B%b D%b R%b W%b A%h O%h L%h exp all 0",
               Busy, Done, MemRD, MemWR, MemAddr, MemDataOut, LoadData);
    end
    @(negedge Clk1);
    Reset = 1'b0;
    @(negedge Clk1);
    #1;
    n_vec++;
    if (Busy !== 1'b0) begin
      n_err++; $display("FAIL idle_after_reset got Busy %b exp 0", Busy);
    end
  endtask

  task automatic test_vld();
    drive_op(1'b0, 16'h0100, 16'h0001, '0, 0, 18, 21, 0, 0, 16'h0000);
  endtask

  task automatic test_vst_wrap();
    drive_op(1'b1, 16'hFFF8, 16'h0001, mk_sdata(16'hA000), 0, 17, 20, 0, 0, 16'h0000);
  endtask

  task automatic test_vld_alt_grant();
    drive_op(1'b0, 16'h0200, 16'h0001, '0, 1, 33, 36, 0, 0, 16'h0000);
  endtask

  task automatic test_start_while_busy();
    drive_op(1'b0, 16'h0400, 16'h0001, '0, 0, 18, 21, 0, 3, 16'h7700);
  endtask

  task automatic test_reset_abort();
    drive_op(1'b1, 16'h3000, 16'h0001, mk_sdata(16'hB000), 0, 0, 25, 5, 0, 16'h0000);
    drive_op(1'b1, 16'h3100, 16'h0001, mk_sdata(16'hC000), 0, 17, 20, 0, 0, 16'h0000);
  endtask

  task automatic test_reset_priority();
    @(negedge Clk1);
    Reset = 1'b1; Start = 1'b1; IsStore = 1'b0; BaseAddr = 16'h5000;
    @(negedge Clk1);
    Reset = 1'b0; Start = 1'b0;
    #1;
    n_vec++;
    if (Busy !== 1'b0 || MemRD !== 1'b0) begin
      n_err++; $display("FAIL reset_priority got Busy %b MemRD %b exp 0 0", Busy, MemRD);
    end
    model_load = '0;
    @(negedge Clk1);
    #1;
    n_vec++;
    if (Busy !== 1'b0 || LoadData !== 256'h0) begin
      n_err++; $display("FAIL reset_priority_idle got Busy %b exp 0", Busy);
    end
  endtask

`ifdef VLS_STRIDE_EN
  task automatic test_stride();
    drive_op(1'b0, 16'h0000, 16'h0010, '0, 0, 18, 21, 0, 0, 16'h0000);
  endtask
`endif

  initial begin
    test_reset();
    test_vld();
    test_vst_wrap();
    test_vld_alt_grant();
    test_start_while_busy();
    test_reset_abort();
    test_reset_priority();
`ifdef VLS_STRIDE_EN
    test_stride();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
